cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Sits directly downstream of the multi-cycle RISC-V core's instruction and data channels.
- Merges both channels onto one shared single-port memory bus. Each side has its own request/response valid-ready handshake.
- Serialises transactions with one outstanding access at a time.
- Buffers read data so the core may delay its acknowledge indefinitely.

Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (0 = reset), sampled on posedge clk
- PC  in  32  instruction fetch address
- Inst_Req_Valid  in  1  core fetch request
- Inst_Req_Ack  out  1  fetch request accepted
- Instruction  out  32  fetched word
- Inst_Valid  out  1  Instruction valid
- Inst_Ack  in  1  core accepts Instruction
- Address  in  32  data address, word aligned by the core
- MemWrite  in  1  store request
- Write_data  in  32  store data
- Write_strb  in  4  byte strobes
- MemRead  in  1  load request
- Mem_Req_Ack  out  1  data request accepted
- Read_data  out  32  load word
- Read_data_Valid  out  1  Read_data valid
- Read_data_Ack  in  1  core accepts Read_data
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_addr  out  32  bus address
- mem_wen  out  1  1 = write, 0 = read
- mem_wdata  out  32  bus write data
- mem_wstrb  out  4  bus strobes
- mem_rsp_valid  in  1  bus read data valid
- mem_rsp_ready  out  1  arbiter accepts read data
- mem_rdata  in  32  bus read data

Behaviour:
- States: IDLE, REQ, RSP, DLV. One-hot encoding. Source tag register `src` (0 = inst, 1 = data).
- Reset (rst=0): the following are all 0.
  - State: IDLE.
  - Outputs: mem_req_valid, mem_rsp_ready, Inst_Valid, Read_data_Valid, Inst_Req_Ack, Mem_Req_Ack.
  - Registers: mem_addr, mem_wdata, mem_wstrb, mem_wen, response buffer, src.
- Reset mid-transaction aborts immediately. No response is delivered afterwards, even if mem_rsp_valid arrives later.
- IDLE, arbitration (combinational acks, IDLE only):
  - Data has fixed priority.
  - Mem_Req_Ack = IDLE & (MemRead | MemWrite).
  - Inst_Req_Ack = IDLE & Inst_Req_Valid & ~(MemRead | MemWrite).
- Acceptance edge:
  - Register the address. For inst, the address is {PC[31:2], 2'b00}.
  - Register mem_wen = MemWrite, plus wdata and wstrb. For inst, wen = 0 and wstrb = 0.
  - Set src, then move to REQ.
  - MemRead and MemWrite both high is illegal. The write wins.
- REQ:
  - mem_req_valid = 1, all bus fields stable.
  - On mem_req_ready, the request is done.
    - Write → IDLE; no response phase.
    - Read → RSP.
- RSP:
  - mem_rsp_ready = 1.
  - On mem_rsp_valid, capture mem_rdata into the buffer → DLV.
- DLV:
  - Drive Instruction/Inst_Valid (src=0) or Read_data/Read_data_Valid (src=1) from the buffer.
  - On the matching ack, go → IDLE. Data stays stable until then.
  - The core's Inst_Ack is allowed high outside DLV and is ignored there.
- Instruction and Read_data both drive the buffer. Each is qualified only by its own valid.
- Latency with a zero-wait bus:
  - Read: ack at cycle 0, bus request at 1, response at 2, valid at 3. IDLE is re-entered at 4 if the ack arrives at 3.
  - Write: ack at 0, bus handshake at 1, IDLE at 2.
- No pipelining. New requests are not acked outside IDLE.
- Back-to-back: a request pending when IDLE is re-entered is acked in that same IDLE cycle.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds the following output ports:
  - inst_grant_cnt (32): counts Inst_Req_Ack cycles.
  - data_grant_cnt (32): counts Mem_Req_Ack cycles.
  - bus_stall_cnt (32): counts cycles in REQ with mem_req_ready=0 plus cycles in RSP with mem_rsp_valid=0.
- Counters reset to 0 and wrap modulo 2^32. Functional behaviour is otherwise identical.
- When not defined, the ports and logic are absent.

Test Plan:
- Fetch, zero-wait bus: PC=0x104 at cycle 0, mem_rdata=0x00500093 → mem_addr=0x104 and mem_wen=0 at cycle 1. Instruction=0x00500093 with Inst_Valid=1 at cycle 3. IDLE at cycle 4.
- Store: Address=0x2000, Write_data=0xAABBCCDD, strb=4'b0100, with mem_req_ready held low 3 cycles → mem_req_valid held for 4 cycles with stable fields. No Read_data_Valid is ever asserted. Back in IDLE the cycle after the handshake.
- Simultaneous MemRead (0x3000) and Inst_Req_Valid → Mem_Req_Ack=1 and Inst_Req_Ack=0. The fetch is acked in the first IDLE cycle after the load's Read_data_Ack.
- Load with delayed ack: Read_data_Ack low 5 cycles after valid → Read_data stays 0x12345678 and Read_data_Valid stays 1 throughout. No new bus request is issued.
- rst=0 asserted while in RSP, then a late mem_rsp_valid → all outputs 0. Inst_Valid and Read_data_Valid never rise. The next fetch proceeds normally.
- ARB_PERF_CNT_EN defined: 3 fetches + 2 loads, each with 2 bus stall cycles → inst_grant_cnt=3, data_grant_cnt=2, bus_stall_cnt=10.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the core's fetch and load/store channels onto one
// single-port memory bus, one access at a time. Optional: ARB_PERF_CNT_EN.
module cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]         inst_grant_cnt,
    output logic [31:0]         data_grant_cnt,
    output logic [31:0]         bus_stall_cnt,
`endif
    input  logic [ADDR_W-1:0]   PC,
    input  logic                Inst_Req_Valid,
    output logic                Inst_Req_Ack,
    output logic [DATA_W-1:0]   Instruction,
    output logic                Inst_Valid,
    input  logic                Inst_Ack,
    input  logic [ADDR_W-1:0]   Address,
    input  logic                MemWrite,
    input  logic [DATA_W-1:0]   Write_data,
    input  logic [DATA_W/8-1:0] Write_strb,
    input  logic                MemRead,
    output logic                Mem_Req_Ack,
    output logic [DATA_W-1:0]   Read_data,
    output logic                Read_data_Valid,
    input  logic                Read_data_Ack,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        REQ  = 4'b0010,
        RSP  = 4'b0100,
        DLV  = 4'b1000
    } state_t;

    state_t              r_state;
    logic                r_src;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_wen;
    logic [DATA_W-1:0]   r_buf;
    logic                r_req_valid;
    logic                r_rsp_ready;
    logic                r_inst_valid;
    logic                r_rd_valid;

    logic w_idle;
    logic w_data_req;
    logic w_data_acc;
    logic w_inst_acc;
    logic w_dlv_ack;

    // Acks are only offered in IDLE and never while reset is held.
    assign w_idle     = (r_state == IDLE) & rst;
    assign w_data_req = MemRead | MemWrite;
    assign w_data_acc = w_idle & w_data_req;
    assign w_inst_acc = w_idle & Inst_Req_Valid & ~w_data_req;
    assign w_dlv_ack  = r_src ? Read_data_Ack : Inst_Ack;

    assign Mem_Req_Ack     = w_data_acc;
    assign Inst_Req_Ack    = w_inst_acc;
    assign mem_req_valid   = r_req_valid;
    assign mem_rsp_ready   = r_rsp_ready;
    assign mem_addr        = r_addr;
    assign mem_wen         = r_wen;
    assign mem_wdata       = r_wdata;
    assign mem_wstrb       = r_wstrb;
    assign Instruction     = r_buf;
    assign Read_data       = r_buf;
    assign Inst_Valid      = r_inst_valid;
    assign Read_data_Valid = r_rd_valid;

    // Transaction FSM: accept, bus request, bus response, deliver to core.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_src        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wen        <= 1'b0;
            r_buf        <= '0;
            r_req_valid  <= 1'b0;
            r_rsp_ready  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_rd_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_data_acc) begin
                        r_addr      <= Address;
                        r_wen       <= MemWrite;
                        r_wdata     <= Write_data;
                        r_wstrb     <= Write_strb;
                        r_src       <= 1'b1;
                        r_req_valid <= 1'b1;
                        r_state     <= REQ;
                    end else if (w_inst_acc) begin
                        r_addr      <= PC & ALIGN_MASK;
                        r_wen       <= 1'b0;
                        r_wdata     <= '0;
                        r_wstrb     <= '0;
                        r_src       <= 1'b0;
                        r_req_valid <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_rsp_ready <= ~r_wen;
                        r_state     <= r_wen ? IDLE : RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid) begin
                        r_buf        <= mem_rdata;
                        r_rsp_ready  <= 1'b0;
                        r_inst_valid <= ~r_src;
                        r_rd_valid   <= r_src;
                        r_state      <= DLV;
                    end
                end
                DLV: begin
                    if (w_dlv_ack) begin
                        r_inst_valid <= 1'b0;
                        r_rd_valid   <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_req_valid  <= 1'b0;
                    r_rsp_ready  <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_rd_valid   <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic w_stall;
    assign w_stall = ((r_state == REQ) & ~mem_req_ready) |
                     ((r_state == RSP) & ~mem_rsp_valid);

    // Free-running grant and bus-stall counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_grant_cnt <= '0;
            data_grant_cnt <= '0;
            bus_stall_cnt  <= '0;
        end else begin
            if (w_inst_acc) inst_grant_cnt <= inst_grant_cnt + 32'd1;
            if (w_data_acc) data_grant_cnt <= data_grant_cnt + 32'd1;
            if (w_stall)    bus_stall_cnt  <= bus_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: randomized transaction-level bench for cpu_mem_arbiter.
// Expected bus fields and delivered data come from a per-transaction model.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;
    logic [31:0] bus_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ARB_PERF_CNT_EN
        .inst_grant_cnt (inst_grant_cnt),
        .data_grant_cnt (data_grant_cnt),
        .bus_stall_cnt  (bus_stall_cnt),
`endif
        .PC             (PC),
        .Inst_Req_Valid (Inst_Req_Valid),
        .Inst_Req_Ack   (Inst_Req_Ack),
        .Instruction    (Instruction),
        .Inst_Valid     (Inst_Valid),
        .Inst_Ack       (Inst_Ack),
        .Address        (Address),
        .MemWrite       (MemWrite),
        .Write_data     (Write_data),
        .Write_strb     (Write_strb),
        .MemRead        (MemRead),
        .Mem_Req_Ack    (Mem_Req_Ack),
        .Read_data      (Read_data),
        .Read_data_Valid(Read_data_Valid),
        .Read_data_Ack  (Read_data_Ack),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_ready  (mem_rsp_ready),
        .mem_rdata      (mem_rdata)
    );

    // kind: 0 fetch, 1 load, 2 store, 3 load+store together (store wins).
    // Entered shortly after a posedge in an IDLE cycle; returns likewise.
    // hold_f keeps a fetch (at fpc) pending across a data transaction.
    task automatic run_txn(input int kind, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] st,
                           input logic [31:0] rd, input int req_st,
                           input int rsp_st, input int ack_dly,
                           input bit hold_f, input logic [31:0] fpc);
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [1:0]  e_ack;
        logic [1:0]  e_vld;
        logic [31:0] got;
        bit          is_wr;
        is_wr  = (kind >= 2);
        e_addr = (kind == 0) ? {addr[31:2], 2'b00} : addr;
        e_strb = (kind == 0) ? 4'h0 : st;
        e_ack  = (kind == 0) ? 2'b10 : 2'b01;
        e_vld  = (kind == 0) ? 2'b10 : 2'b01;
        if (kind == 0) begin
            PC = addr;
            Inst_Req_Valid = 1'b1;
        end else begin
            Address    = addr;
            MemRead    = (kind != 2);
            MemWrite   = (kind >= 2);
            Write_data = wd;
            Write_strb = st;
        end
        if (hold_f) begin
            PC = fpc;
            Inst_Req_Valid = 1'b1;
        end
        #1;
        n_cmp++;
        if ({Inst_Req_Ack, Mem_Req_Ack} !== e_ack) begin
            n_err++;
            $display("FAIL accept_ack kind=%0d got %b want %b",
                     kind, {Inst_Req_Ack, Mem_Req_Ack}, e_ack);
        end
        @(posedge clk); #1;
        Inst_Req_Valid = hold_f ? 1'b1 : 1'($urandom % 2);
        PC         = hold_f ? fpc : $urandom;
        MemRead    = 1'($urandom % 2);
        MemWrite   = 1'b0;
        Address    = $urandom;
        Write_data = $urandom;
        Write_strb = 4'($urandom);
        for (int s = 0; s <= req_st; s++) begin
            mem_req_ready = (s == req_st);
            Inst_Ack      = 1'($urandom % 2);
            Read_data_Ack = 1'($urandom % 2);
            #1;
            n_cmp++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_wstrb} !==
                {1'b1, e_addr, 1'(is_wr), e_strb}) begin
                n_err++;
                $display("FAIL req_fields got v=%b a=%h w=%b s=%b want a=%h w=%b s=%b",
                         mem_req_valid, mem_addr, mem_wen, mem_wstrb,
                         e_addr, is_wr, e_strb);
            end
            if (is_wr) begin
                n_cmp++;
                if (mem_wdata !== wd) begin
                    n_err++;
                    $display("FAIL req_wdata got %h want %h", mem_wdata, wd);
                end
            end
            n_cmp++;
            if ({Inst_Req_Ack, Mem_Req_Ack, mem_rsp_ready,
                 Inst_Valid, Read_data_Valid} !== 5'b0) begin
                n_err++;
                $display("FAIL busy_req got %b want 00000",
                         {Inst_Req_Ack, Mem_Req_Ack, mem_rsp_ready,
                          Inst_Valid, Read_data_Valid});
            end
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
        if (!is_wr) begin
            for (int s = 0; s <= rsp_st; s++) begin
                mem_rsp_valid = (s == rsp_st);
                mem_rdata     = (s == rsp_st) ? rd : $urandom;
                Inst_Ack      = 1'($urandom % 2);
                Read_data_Ack = 1'($urandom % 2);
                #1;
                n_cmp++;
                if ({mem_rsp_ready, mem_req_valid, Inst_Valid,
                     Read_data_Valid, Inst_Req_Ack, Mem_Req_Ack} !== 6'b100000) begin
                    n_err++;
                    $display("FAIL rsp_phase got %b want 100000",
                             {mem_rsp_ready, mem_req_valid, Inst_Valid,
                              Read_data_Valid, Inst_Req_Ack, Mem_Req_Ack});
                end
                @(posedge clk); #1;
            end
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
            for (int d = 0; d <= ack_dly; d++) begin
                if (kind == 0) begin
                    Inst_Ack      = (d == ack_dly);
                    Read_data_Ack = 1'($urandom % 2);
                end else begin
                    Read_data_Ack = (d == ack_dly);
                    Inst_Ack      = 1'($urandom % 2);
                end
                #1;
                got = (kind == 0) ? Instruction : Read_data;
                n_cmp++;
                if ({Inst_Valid, Read_data_Valid} !== e_vld || got !== rd) begin
                    n_err++;
                    $display("FAIL deliver kind=%0d got vld=%b d=%h want vld=%b d=%h",
                             kind, {Inst_Valid, Read_data_Valid}, got, e_vld, rd);
                end
                n_cmp++;
                if ({mem_req_valid, mem_rsp_ready,
                     Inst_Req_Ack, Mem_Req_Ack} !== 4'b0) begin
                    n_err++;
                    $display("FAIL busy_dlv got %b want 0000",
                             {mem_req_valid, mem_rsp_ready, Inst_Req_Ack, Mem_Req_Ack});
                end
                @(posedge clk); #1;
            end
        end
        Inst_Ack      = 1'b0;
        Read_data_Ack = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        if (!hold_f) Inst_Req_Valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        Inst_Req_Valid = 1'b1;
        MemRead = 1'b1;
        PC = 32'h0000_0040;
        Address = 32'h0000_0080;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({mem_req_valid, mem_rsp_ready, Inst_Valid, Read_data_Valid,
             Inst_Req_Ack, Mem_Req_Ack, mem_addr, mem_wdata, mem_wstrb,
             mem_wen, Instruction, Read_data} !== '0) begin
            n_err++;
            $display("FAIL reset_state va=%b%b%b%b%b%b a=%h wd=%h s=%b w=%b i=%h r=%h",
                     mem_req_valid, mem_rsp_ready, Inst_Valid, Read_data_Valid,
                     Inst_Req_Ack, Mem_Req_Ack, mem_addr, mem_wdata, mem_wstrb,
                     mem_wen, Instruction, Read_data);
        end
        Inst_Req_Valid = 1'b0;
        MemRead = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        run_txn(0, 32'h0000_0104, 0, 0, 32'h0050_0093, 0, 0, 0, 0, 0);
        run_txn(0, 32'h0000_0108, 0, 0, 32'h0010_0113, 0, 0, 0, 0, 0);
    endtask

    task automatic test_store();
        run_txn(2, 32'h0000_2000, 32'hAABB_CCDD, 4'b0100, 0, 3, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if ({mem_req_valid, mem_rsp_ready, Read_data_Valid, Inst_Valid} !== 4'b0) begin
            n_err++;
            $display("FAIL store_after got %b want 0000",
                     {mem_req_valid, mem_rsp_ready, Read_data_Valid, Inst_Valid});
        end
        run_txn(0, 32'h0000_0300, 0, 0, 32'hCAFE_0001, 0, 0, 0, 0, 0);
        run_txn(3, 32'h0000_2004, 32'h1122_3344, 4'b1111, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_priority();
        run_txn(1, 32'h0000_3000, 0, 0, 32'h0BAD_F00D, 0, 0, 1,
                1, 32'h0000_0200);
        #1;
        n_cmp++;
        if ({Inst_Req_Ack, Mem_Req_Ack} !== 2'b10) begin
            n_err++;
            $display("FAIL pending_fetch_ack got %b want 10",
                     {Inst_Req_Ack, Mem_Req_Ack});
        end
        run_txn(0, 32'h0000_0200, 0, 0, 32'h0000_0013, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_delay();
        run_txn(1, 32'h0000_4000, 0, 0, 32'h1234_5678, 0, 0, 5, 0, 0);
    endtask

    task automatic test_reset_mid();
        Address = 32'h0000_5000;
        MemRead = 1'b1;
        #1;
        n_cmp++;
        if (Mem_Req_Ack !== 1'b1) begin
            n_err++;
            $display("FAIL mid_accept got %b want 1", Mem_Req_Ack);
        end
        @(posedge clk); #1;
        MemRead = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        n_cmp++;
        if (mem_rsp_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_in_rsp got %b want 1", mem_rsp_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_req_valid, mem_rsp_ready, Inst_Valid, Read_data_Valid,
             Inst_Req_Ack, Mem_Req_Ack, mem_addr, mem_wen, mem_wstrb,
             Read_data} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outs a=%h v=%b%b%b%b%b%b r=%h",
                     mem_addr, mem_req_valid, mem_rsp_ready, Inst_Valid,
                     Read_data_Valid, Inst_Req_Ack, Mem_Req_Ack, Read_data);
        end
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({Inst_Valid, Read_data_Valid, mem_rsp_ready, mem_req_valid} !== 4'b0) begin
                n_err++;
                $display("FAIL late_rsp cyc=%0d got %b want 0000", k,
                         {Inst_Valid, Read_data_Valid, mem_rsp_ready, mem_req_valid});
            end
        end
        mem_rsp_valid = 1'b0;
        run_txn(0, 32'h0000_0400, 0, 0, 32'h0000_0517, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int          kind;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a = $urandom;
            if (kind != 0) a[1:0] = 2'b00;
            run_txn(kind, a, $urandom, 4'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 0, 0);
        end
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            run_txn(0, 32'h100 + 32'(4 * i), 0, 0, $urandom, 1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++)
            run_txn(1, 32'h800 + 32'(4 * i), 0, 0, $urandom, 1, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if ({inst_grant_cnt, data_grant_cnt, bus_stall_cnt} !==
            {32'd3, 32'd2, 32'd10}) begin
            n_err++;
            $display("FAIL perf_cnt got %0d/%0d/%0d want 3/2/10",
                     inst_grant_cnt, data_grant_cnt, bus_stall_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        PC = '0;
        Inst_Req_Valid = 1'b0;
        Inst_Ack = 1'b0;
        Address = '0;
        MemWrite = 1'b0;
        Write_data = '0;
        Write_strb = '0;
        MemRead = 1'b0;
        Read_data_Ack = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_load_delay();
        test_reset_mid();
        test_random();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
